acc_rx_sequencer: RTL

Controls the accumulator datapath fed by the UART receiver. It consumes received bytes and classifies each one as CLEAR, SEND or data. Data bytes are added into a 16-bit accumulator. SEND transmits the accumulator as two bytes, high byte first, through the UART transmitter handshake. The block sits between the UART RX state machine/shift register and the UART TX block, all on CLOCK_50.

---
 rtl/acc_uart_pkg.sv | 21 ++
 rtl/acc_rx_pending_slot.sv | 33 +++
 rtl/acc_rx_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/acc_uart_pkg.sv
// Shared constants for the UART accumulator path: FSM encoding, command bytes
// and the error counter ceiling.
package acc_uart_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ADD     = 3'd1;
  localparam logic [2:0] CLR     = 3'd2;
  localparam logic [2:0] SEND_HI = 3'd3;
  localparam logic [2:0] WAIT_HI = 3'd4;
  localparam logic [2:0] SEND_LO = 3'd5;
  localparam logic [2:0] WAIT_LO = 3'd6;

  localparam logic [7:0] CMD_CLEAR_DEF = 8'h43;
  localparam logic [7:0] CMD_SEND_DEF  = 8'h3D;
  localparam logic [7:0] ERR_MAX       = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/acc_rx_pending_slot.sv
// One-entry holding register between the UART receiver and the sequencer FSM.
// A write lands only when the slot is empty or being drained the same cycle.
module acc_rx_pending_slot (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr,
  input  logic [7:0] i_data,
  input  logic       i_consume,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_overrun
);

  logic       r_valid;
  logic [7:0] r_data;

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_overrun = i_wr & r_valid & ~i_consume;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
    end else if (i_wr && (!r_valid || i_consume)) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/acc_rx_sequencer.sv
// Classifies received bytes into CLEAR / SEND / data, accumulates data bytes
// and streams a snapshot of the accumulator out high byte first.
module acc_rx_sequencer
  import acc_uart_pkg::*;
#(
  parameter logic [7:0] CMD_CLEAR = CMD_CLEAR_DEF,
  parameter logic [7:0] CMD_SEND  = CMD_SEND_DEF,
  parameter int         ACC_W     = 16
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_ferr,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [ACC_W-1:0] acc_value,
  output logic             overflow,
  output logic [7:0]       err_count,
  output logic             busy
);

  logic [2:0]       r_state;
  logic [7:0]       r_cur;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_snap;
  logic             r_ovf;
  logic             r_seen;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;
  logic [7:0]       r_err;

  logic             w_slot_vld;
  logic [7:0]       w_slot_data;
  logic             w_overrun;
  logic             w_consume;
  logic [ACC_W:0]   w_sum;

  assign w_consume = (r_state == IDLE) && w_slot_vld;
  assign w_sum     = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, r_cur};

  acc_rx_pending_slot u_slot (
    .i_clk     (CLOCK_50),
    .i_rst     (Reset),
    .i_wr      (rx_valid & ~rx_ferr),
    .i_data    (rx_data),
    .i_consume (w_consume),
    .o_valid   (w_slot_vld),
    .o_data    (w_slot_data),
    .o_overrun (w_overrun)
  );

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_cur      <= 8'h00;
      r_acc      <= '0;
      r_snap     <= '0;
      r_ovf      <= 1'b0;
      r_seen     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_err      <= 8'h00;
    end else begin
      r_tx_start <= 1'b0;
      // a framing error and an overrun on the same byte count only once
      if (rx_valid && (rx_ferr || w_overrun))
        r_err <= sat_inc(r_err);

      case (r_state)
        IDLE: begin
          if (w_slot_vld) begin
            r_cur <= w_slot_data;
            if (w_slot_data == CMD_CLEAR) begin
              r_state <= CLR;
            end else if (w_slot_data == CMD_SEND) begin
              r_state <= SEND_HI;
              r_snap  <= r_acc;
            end else begin
              r_state <= ADD;
            end
          end
        end
        ADD: begin
          r_acc <= w_sum[ACC_W-1:0];
          if (w_sum[ACC_W]) r_ovf <= 1'b1;
          r_state <= IDLE;
        end
        CLR: begin
          r_acc   <= '0;
          r_ovf   <= 1'b0;
          r_state <= IDLE;
        end
        SEND_HI: begin
          if (!tx_busy) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= r_snap[ACC_W-1 -: 8];
            r_seen     <= 1'b0;
            r_state    <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          // the transmitter only raises busy a cycle after tx_start
          if (tx_busy)     r_seen  <= 1'b1;
          else if (r_seen) r_state <= SEND_LO;
        end
        SEND_LO: begin
          if (!tx_busy) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= r_snap[7:0];
            r_seen     <= 1'b0;
            r_state    <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (tx_busy)     r_seen  <= 1'b1;
          else if (r_seen) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;
  assign acc_value = r_acc;
  assign overflow  = r_ovf;
  assign err_count = r_err;
  assign busy      = (r_state != IDLE) || w_slot_vld;

endmodule
